// File: rtl/uart_pkg.sv
// Shared UART package: default payload width and buffer depth, plus the
// launch-FSM state encoding used by the transmit-side FIFO. The receive and
// transmit blocks import this package so that they agree on the defaults.
package uart_pkg;

  // Default width of one UART payload word.
  localparam int UART_PAYLOAD_BITS = 8;

  // Default number of buffered words in the transmit FIFO (power of two, >= 2).
  localparam int UART_FIFO_DEPTH = 16;

  // Cycles the launcher waits in WAIT_BUSY for uart_tx to acknowledge a launch.
  localparam int TX_BUSY_TIMEOUT = 4;
  localparam int TX_TMO_W        = $clog2(TX_BUSY_TIMEOUT);

  // Launch FSM states.
  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_LAUNCH    = 2'd1,
    TX_WAIT_BUSY = 2'd2,
    TX_WAIT_DONE = 2'd3
  } tx_state_e;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage for the transmit FIFO.
// One write port and one registered read port; the array and the read
// register are deliberately not reset, so the array maps onto block RAM.
//
// Ports:
//   clk      - system clock, rising edge
//   wr_en    - write strobe; wr_data is stored at wr_addr
//   wr_addr  - write address
//   wr_data  - word to store
//   rd_en    - read strobe; mem[rd_addr] is registered into rd_data
//   rd_addr  - read address
//   rd_data  - registered read data, holds until the next rd_en
module uart_fifo_mem #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule : uart_fifo_mem

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO in front of a uart_tx core.
// Buffers words from a valid/ready producer and launches them one at a time
// into uart_tx with a one-cycle strobe, using uart_tx_busy as the handshake.
// If uart_tx never raises busy after a launch, the launcher gives up after
// TX_BUSY_TIMEOUT cycles, flags tx_timeout and moves on to the next word.
//
// Ports:
//   clk           - system clock, rising edge
//   resetn        - asynchronous active-low reset
//   wr_valid      - producer presents wr_data
//   wr_ready      - FIFO can accept a word this cycle (!fifo_full)
//   wr_data       - word to enqueue
//   uart_tx_busy  - busy flag from downstream uart_tx
//   uart_tx_en    - one-cycle launch strobe to uart_tx
//   uart_tx_data  - word being launched; holds until the next pop
//   fifo_count    - words currently stored
//   fifo_empty    - fifo_count == 0
//   fifo_full     - fifo_count == DEPTH
//   overflow      - sticky: a write was attempted while full
//   tx_timeout    - sticky: uart_tx_busy never rose after a launch
//
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int PAYLOAD_BITS = UART_PAYLOAD_BITS,
  parameter int DEPTH        = UART_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [PAYLOAD_BITS-1:0]  wr_data,
  input  logic                     uart_tx_busy,
  output logic                     uart_tx_en,
  output logic [PAYLOAD_BITS-1:0]  uart_tx_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic                     overflow,
  output logic                     tx_timeout
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // State registers and their next values
  tx_state_e            state_q, state_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [TX_TMO_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic                 overflow_q, overflow_d;
  logic                 tx_timeout_q, tx_timeout_d;
  logic                 data_loaded_q, data_loaded_d;

  logic                    push;
  logic                    pop;
  logic [PAYLOAD_BITS-1:0] mem_rd_data;

  assign fifo_count = count_q;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  // Ready comes from the registered count only: a word arriving in the cycle
  // that a pop frees the last slot is refused.
  assign wr_ready   = !fifo_full;
  assign push       = wr_valid && wr_ready;

  assign overflow   = overflow_q;
  assign tx_timeout = tx_timeout_q;
  assign uart_tx_en = (state_q == TX_LAUNCH);

  // The memory's read register doubles as the launch data register. It has
  // no reset, so the output is forced to zero until the first pop after
  // reset has loaded it.
  assign uart_tx_data = data_loaded_q ? mem_rd_data : '0;

  uart_fifo_mem #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_addr (rd_ptr_q),
    .rd_data (mem_rd_data)
  );

  // Launch FSM: next state, pop decision, timeout tracking.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    tx_timeout_d  = tx_timeout_q;
    data_loaded_d = data_loaded_q;
    pop           = 1'b0;

    unique case (state_q)
      TX_IDLE: begin
        if (!fifo_empty && !uart_tx_busy) begin
          pop           = 1'b1;
          data_loaded_d = 1'b1;
          state_d       = TX_LAUNCH;
        end
      end
      TX_LAUNCH: begin
        wait_cnt_d = '0;
        state_d    = TX_WAIT_BUSY;
      end
      TX_WAIT_BUSY: begin
        if (uart_tx_busy) begin
          state_d = TX_WAIT_DONE;
        end else if (wait_cnt_q == TX_TMO_W'(TX_BUSY_TIMEOUT - 1)) begin
          // Last allowed cycle without busy: abandon this launch.
          tx_timeout_d = 1'b1;
          state_d      = TX_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + TX_TMO_W'(1);
        end
      end
      TX_WAIT_DONE: begin
        if (!uart_tx_busy) begin
          state_d = TX_IDLE;
        end
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase
  end

  // Pointers, occupancy and overflow. Pointers are PTR_W bits wide and wrap
  // from DEPTH-1 to 0 by natural overflow.
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    overflow_d = overflow_q || (wr_valid && fifo_full);

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;  // idle, or simultaneous push and pop
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= TX_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      wait_cnt_q    <= '0;
      overflow_q    <= 1'b0;
      tx_timeout_q  <= 1'b0;
      data_loaded_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      wait_cnt_q    <= wait_cnt_d;
      overflow_q    <= overflow_d;
      tx_timeout_q  <= tx_timeout_d;
      data_loaded_q <= data_loaded_d;
    end
  end

endmodule : uart_tx_fifo

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (PAYLOAD_BITS=8, DEPTH=16).
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_data = 8'h00;
  logic       uart_tx_busy = 1'b0;
  logic       uart_tx_en;
  logic [7:0] uart_tx_data;
  logic [4:0] fifo_count;
  logic       fifo_empty;
  logic       fifo_full;
  logic       overflow;
  logic       tx_timeout;

  int checks   = 0;
  int failures = 0;

  // Launch monitor: every strobe cycle records the launched word.
  logic [7:0] launched_q[$];
  logic       en_prev   = 1'b0;
  int         double_en = 0;

  uart_tx_fifo #(.PAYLOAD_BITS(8), .DEPTH(16)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .uart_tx_busy (uart_tx_busy),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data),
    .fifo_count   (fifo_count),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .overflow     (overflow),
    .tx_timeout   (tx_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (uart_tx_en) begin
      launched_q.push_back(uart_tx_data);
      if (en_prev) double_en++;
    end
    en_prev = uart_tx_en;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at posedge+1 with resetn just released, so the next
  // edge is the first one after deassertion.
  task automatic apply_reset();
    wr_valid = 1'b0;
    wr_data = 8'h00;
    uart_tx_busy = 1'b0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    launched_q.delete();
  endtask

  task automatic test_reset();
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    checks++; if (uart_tx_en !== 1'b0) begin failures++; $display("FAIL reset_en: got %b want 0", uart_tx_en); end
    checks++; if (uart_tx_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h want 00", uart_tx_data); end
    checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    checks++; if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin failures++; $display("FAIL reset_flags: empty=%b full=%b want 1 0", fifo_empty, fifo_full); end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", wr_ready); end
    checks++; if (overflow !== 1'b0 || tx_timeout !== 1'b0) begin failures++; $display("FAIL reset_sticky: ovf=%b tmo=%b want 0 0", overflow, tx_timeout); end
    $display("test_reset done");
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    wr_valid = 1'b1;   // cycle N: first edge after reset release
    wr_data = 8'h41;
    tick();            // N+1
    wr_valid = 1'b0;
    checks++; if (fifo_count !== 5'd1 || fifo_empty !== 1'b0) begin failures++; $display("FAIL single_count: count=%0d empty=%b want 1 0", fifo_count, fifo_empty); end
    checks++; if (uart_tx_en !== 1'b0) begin failures++; $display("FAIL single_early_en: got %b want 0", uart_tx_en); end
    tick();            // N+2
    checks++; if (uart_tx_en !== 1'b1 || uart_tx_data !== 8'h41) begin failures++; $display("FAIL single_launch: en=%b data=%h want 1 41", uart_tx_en, uart_tx_data); end
    checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL single_empty: got %b want 1", fifo_empty); end
    tick();            // N+3
    checks++; if (uart_tx_en !== 1'b0 || uart_tx_data !== 8'h41) begin failures++; $display("FAIL single_hold: en=%b data=%h want 0 41", uart_tx_en, uart_tx_data); end
    $display("test_single: launched %h", uart_tx_data);
  endtask

  task automatic test_push_pop_same_cycle();
    apply_reset();
    wr_valid = 1'b1;
    wr_data = 8'hA5;
    tick();
    wr_data = 8'h5A;   // pushed in the same cycle A5 is popped
    tick();
    wr_valid = 1'b0;
    checks++; if (fifo_count !== 5'd1) begin failures++; $display("FAIL pushpop_count: got %0d want 1", fifo_count); end
    checks++; if (uart_tx_en !== 1'b1 || uart_tx_data !== 8'hA5) begin failures++; $display("FAIL pushpop_first: en=%b data=%h want 1 a5", uart_tx_en, uart_tx_data); end
    repeat (12) tick();
    checks++; if (launched_q.size() !== 2 || launched_q[launched_q.size()-1] !== 8'h5A) begin failures++; $display("FAIL pushpop_second: n=%0d want 2 ending 5a", launched_q.size()); end
    $display("test_push_pop_same_cycle: %0d words launched", launched_q.size());
  endtask

  task automatic test_fill();
    apply_reset();
    uart_tx_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1;
      wr_data = 8'(i);
      tick();
    end
    checks++; if (fifo_full !== 1'b1 || wr_ready !== 1'b0 || fifo_count !== 5'd16) begin failures++; $display("FAIL fill_full: full=%b ready=%b count=%0d want 1 0 16", fifo_full, wr_ready, fifo_count); end
    wr_data = 8'hFF;
    tick();
    checks++; if (overflow !== 1'b1 || fifo_count !== 5'd16) begin failures++; $display("FAIL fill_overflow: ovf=%b count=%0d want 1 16", overflow, fifo_count); end
    // Keep offering FF while the first pop frees a slot: still refused.
    uart_tx_busy = 1'b0;
    tick();
    wr_valid = 1'b0;
    checks++; if (fifo_count !== 5'd15 || wr_ready !== 1'b1) begin failures++; $display("FAIL fill_refuse_on_free: count=%0d ready=%b want 15 1", fifo_count, wr_ready); end
    for (int k = 0; k < 200 && launched_q.size() < 16; k++) tick();
    repeat (10) tick();
    checks++; if (launched_q.size() !== 16) begin failures++; $display("FAIL fill_drain_count: got %0d want 16", launched_q.size()); end
    for (int i = 0; i < 16 && i < launched_q.size(); i++) begin
      checks++; if (launched_q[i] !== 8'(i)) begin failures++; $display("FAIL fill_order[%0d]: got %h want %h", i, launched_q[i], 8'(i)); end
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL fill_overflow_sticky: got %b want 1", overflow); end
    $display("test_fill: %0d words launched", launched_q.size());
  endtask

  task automatic test_busy_handshake();
    int pend = 0;
    int left = 0;
    int bad = 0;
    int periods = 0;
    apply_reset();
    uart_tx_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data = 8'h31 + 8'(i);
      tick();
    end
    wr_valid = 1'b0;
    // uart_tx model: busy rises the cycle after each strobe, lasts 10 cycles.
    repeat (60) begin
      if (pend != 0) begin left = 10; pend = 0; periods++; end
      uart_tx_busy = (left > 0);
      if (left > 0) left--;
      if (uart_tx_en && uart_tx_busy) bad++;
      if (uart_tx_en) pend = 1;
      tick();
    end
    uart_tx_busy = 1'b0;
    checks++; if (bad !== 0) begin failures++; $display("FAIL busy_en_while_busy: got %0d want 0", bad); end
    checks++; if (launched_q.size() !== 3 || periods !== 3) begin failures++; $display("FAIL busy_launches: launches=%0d periods=%0d want 3 3", launched_q.size(), periods); end
    for (int i = 0; i < 3 && i < launched_q.size(); i++) begin
      checks++; if (launched_q[i] !== 8'h31 + 8'(i)) begin failures++; $display("FAIL busy_order[%0d]: got %h want %h", i, launched_q[i], 8'h31 + 8'(i)); end
    end
    checks++; if (tx_timeout !== 1'b0) begin failures++; $display("FAIL busy_no_timeout: got %b want 0", tx_timeout); end
    $display("test_busy_handshake: %0d launches", launched_q.size());
  endtask

  task automatic test_wrap();
    int max_cnt = 0;
    apply_reset();
    for (int b = 0; b < 8; b++) begin
      for (int j = 0; j < 5; j++) begin
        wr_valid = 1'b1;
        wr_data = 8'h80 + 8'(b * 5 + j);
        tick();
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      end
      wr_valid = 1'b0;
      for (int k = 0; k < 100 && launched_q.size() < (b + 1) * 5; k++) tick();
    end
    repeat (8) tick();
    checks++; if (launched_q.size() !== 40) begin failures++; $display("FAIL wrap_count: got %0d want 40", launched_q.size()); end
    for (int i = 0; i < 40 && i < launched_q.size(); i++) begin
      checks++; if (launched_q[i] !== 8'h80 + 8'(i)) begin failures++; $display("FAIL wrap_order[%0d]: got %h want %h", i, launched_q[i], 8'h80 + 8'(i)); end
    end
    checks++; if (max_cnt > 5 || fifo_empty !== 1'b1) begin failures++; $display("FAIL wrap_occupancy: max=%0d empty=%b want <=5 1", max_cnt, fifo_empty); end
    $display("test_wrap: %0d words, peak count %0d", launched_q.size(), max_cnt);
  endtask

  task automatic test_timeout();
    apply_reset();
    wr_valid = 1'b1;
    wr_data = 8'h11;
    tick();
    wr_data = 8'h22;
    tick();
    wr_valid = 1'b0;
    checks++; if (uart_tx_en !== 1'b1 || uart_tx_data !== 8'h11) begin failures++; $display("FAIL tmo_launch1: en=%b data=%h want 1 11", uart_tx_en, uart_tx_data); end
    repeat (4) tick();  // fourth WAIT_BUSY cycle
    checks++; if (tx_timeout !== 1'b0) begin failures++; $display("FAIL tmo_early: got %b want 0", tx_timeout); end
    tick();
    checks++; if (tx_timeout !== 1'b1 || uart_tx_en !== 1'b0) begin failures++; $display("FAIL tmo_set: tmo=%b en=%b want 1 0", tx_timeout, uart_tx_en); end
    tick();
    checks++; if (uart_tx_en !== 1'b1 || uart_tx_data !== 8'h22) begin failures++; $display("FAIL tmo_next_launch: en=%b data=%h want 1 22", uart_tx_en, uart_tx_data); end
    $display("test_timeout: tx_timeout=%b", tx_timeout);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data = 8'hC0 + 8'(i);
      if (i == 3) uart_tx_busy = 1'b1;  // first WAIT_BUSY cycle of word C0
      tick();
    end
    wr_valid = 1'b0;
    checks++; if (fifo_count !== 5'd3 || uart_tx_en !== 1'b0) begin failures++; $display("FAIL mid_pre: count=%0d en=%b want 3 0", fifo_count, uart_tx_en); end
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (uart_tx_en !== 1'b0 || fifo_count !== 5'd0 || fifo_empty !== 1'b1) begin failures++; $display("FAIL mid_async: en=%b count=%0d empty=%b want 0 0 1", uart_tx_en, fifo_count, fifo_empty); end
    checks++; if (uart_tx_data !== 8'h00) begin failures++; $display("FAIL mid_data: got %h want 00", uart_tx_data); end
    repeat (2) @(posedge clk);
    #1;
    launched_q.delete();
    uart_tx_busy = 1'b0;
    resetn = 1'b1;
    repeat (30) tick();
    checks++; if (launched_q.size() !== 0 || fifo_empty !== 1'b1) begin failures++; $display("FAIL mid_stale: launches=%0d empty=%b want 0 1", launched_q.size(), fifo_empty); end
    $display("test_reset_mid: %0d launches after release", launched_q.size());
  endtask

  initial begin
    test_reset();
    test_single();
    test_push_pop_same_cycle();
    test_fill();
    test_busy_handshake();
    test_wrap();
    test_timeout();
    test_reset_mid();
    checks++; if (double_en !== 0) begin failures++; $display("FAIL strobe_width: multi-cycle strobes=%0d want 0", double_en); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_tx_fifo
